// File: rtl/dmem_interface.sv
// dmem_interface
// Load/store unit between the execution stage and the D-cache port.
// Captures one memory operation, issues it on the DMEM request channel with a
// rolling 8-bit tag, follows it through exception check, NACK reissue, kill
// and response, and returns load data or a memory exception to write-back.
//
// Ports
//   clk, rst                      core clock, synchronous active-high reset
//   kill                          flush from control
//   req_valid/cmd/type/addr/data/rd   operation from execution
//   stall                         freezes IF..EXE while a transaction runs
//   resp_valid/resp_data/resp_rd  one-cycle completion to write-back
//   xcpt_valid/xcpt_cause         one-cycle memory exception
//   dmem_req_*                    D-cache request channel (valid/ready, payload, tag, kill)
//   dmem_resp_*                   D-cache response channel (valid, tag, data, has_data, nack)
//   dmem_xcpt_*                   exception flags, valid in the cycle after acceptance
//
// state | meaning
// IDLE  | waiting for an operation from execution
// ISSUE | request presented on DMEM, waiting for ready
// CHECK | first cycle after acceptance, exception flags valid
// WAIT  | waiting for a matching response or NACK
// DRAIN | killed; waiting for the request to retire silently
// DONE  | one-cycle completion/exception pulse
module dmem_interface (
    input  logic        clk,
    input  logic        rst,
    input  logic        kill,
    input  logic        req_valid,
    input  logic [4:0]  req_cmd,
    input  logic [2:0]  req_type,
    input  logic [39:0] req_addr,
    input  logic [63:0] req_data,
    input  logic [4:0]  req_rd,
    output logic        stall,
    output logic        resp_valid,
    output logic [63:0] resp_data,
    output logic [4:0]  resp_rd,
    output logic        xcpt_valid,
    output logic [3:0]  xcpt_cause,
    output logic        dmem_req_valid,
    input  logic        dmem_req_ready,
    output logic [4:0]  dmem_req_cmd,
    output logic [2:0]  dmem_op_type,
    output logic [39:0] dmem_req_bits_addr,
    output logic [63:0] dmem_req_bits_data,
    output logic [7:0]  dmem_req_bits_tag,
    output logic        dmem_req_bits_kill,
    input  logic        dmem_resp_valid,
    input  logic [7:0]  dmem_resp_bits_tag,
    input  logic [63:0] dmem_resp_bits_data_subw,
    input  logic        dmem_resp_bits_has_data,
    input  logic        dmem_resp_bits_nack,
    input  logic        dmem_xcpt_ma_ld,
    input  logic        dmem_xcpt_ma_st,
    input  logic        dmem_xcpt_pf_ld,
    input  logic        dmem_xcpt_pf_st
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        CHECK = 3'd2,
        WAIT  = 3'd3,
        DRAIN = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t      state, next_state;
    logic [7:0]  tag_q;
    logic [7:0]  issued_tag;
    logic [4:0]  pay_cmd;
    logic [2:0]  pay_type;
    logic [39:0] pay_addr;
    logic [63:0] pay_data;
    logic [4:0]  pay_rd;

    logic        accept;
    logic        capture;
    logic        resp_match;
    logic        any_xcpt;
    logic [3:0]  cause;
    logic        done_resp;
    logic        done_xcpt;

    assign accept     = dmem_req_valid & dmem_req_ready;
    assign capture    = (state == IDLE) & req_valid & ~kill;
    assign resp_match = dmem_resp_valid & (dmem_resp_bits_tag == issued_tag);
    assign any_xcpt   = dmem_xcpt_ma_ld | dmem_xcpt_ma_st | dmem_xcpt_pf_ld | dmem_xcpt_pf_st;

    always_comb begin
        cause = 4'd15;
        if (dmem_xcpt_ma_ld)      cause = 4'd4;
        else if (dmem_xcpt_ma_st) cause = 4'd6;
        else if (dmem_xcpt_pf_ld) cause = 4'd13;
    end

    assign dmem_req_cmd       = pay_cmd;
    assign dmem_op_type       = pay_type;
    assign dmem_req_bits_addr = pay_addr;
    assign dmem_req_bits_data = pay_data;
    assign dmem_req_bits_tag  = tag_q;

    always_comb begin
        next_state         = state;
        stall              = 1'b0;
        dmem_req_valid     = 1'b0;
        dmem_req_bits_kill = 1'b0;
        done_resp          = 1'b0;
        done_xcpt          = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid && !kill) begin
                    stall      = 1'b1;
                    next_state = ISSUE;
                end
            end
            ISSUE: begin
                stall = 1'b1;
                // a kill before acceptance withdraws the request entirely
                if (kill) begin
                    next_state = IDLE;
                end else begin
                    dmem_req_valid = 1'b1;
                    if (dmem_req_ready) next_state = CHECK;
                end
            end
            CHECK: begin
                stall = 1'b1;
                if (any_xcpt) begin
                    done_xcpt  = 1'b1;
                    next_state = DONE;
                end else if (kill) begin
                    dmem_req_bits_kill = 1'b1;
                    next_state         = DRAIN;
                end else if (dmem_resp_bits_nack) begin
                    next_state = ISSUE;
                end else if (resp_match) begin
                    done_resp  = 1'b1;
                    next_state = DONE;
                end else begin
                    next_state = WAIT;
                end
            end
            WAIT: begin
                stall = 1'b1;
                if (dmem_resp_bits_nack) begin
                    next_state = ISSUE;
                end else if (resp_match) begin
                    done_resp  = 1'b1;
                    next_state = DONE;
                end else if (kill) begin
                    next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (resp_match || dmem_resp_bits_nack) next_state = IDLE;
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            tag_q      <= 8'd0;
            issued_tag <= 8'd0;
            pay_cmd    <= 5'd0;
            pay_type   <= 3'd0;
            pay_addr   <= 40'd0;
            pay_data   <= 64'd0;
            pay_rd     <= 5'd0;
            resp_valid <= 1'b0;
            resp_data  <= 64'd0;
            resp_rd    <= 5'd0;
            xcpt_valid <= 1'b0;
            xcpt_cause <= 4'd0;
        end else begin
            state <= next_state;
            if (accept) begin
                issued_tag <= tag_q;
                tag_q      <= tag_q + 8'd1;
            end
            if (capture) begin
                pay_cmd  <= req_cmd;
                pay_type <= req_type;
                pay_addr <= req_addr;
                pay_data <= req_data;
                pay_rd   <= req_rd;
            end
            resp_valid <= done_resp;
            xcpt_valid <= done_xcpt;
            if (done_resp) begin
                resp_data <= dmem_resp_bits_has_data ? dmem_resp_bits_data_subw : 64'd0;
                resp_rd   <= pay_rd;
            end
            if (done_xcpt) xcpt_cause <= cause;
        end
    end

endmodule

// File: tb/tb_dmem_interface.sv
module tb_dmem_interface;

    logic        clk = 1'b0;
    logic        rst;
    logic        kill;
    logic        req_valid;
    logic [4:0]  req_cmd;
    logic [2:0]  req_type;
    logic [39:0] req_addr;
    logic [63:0] req_data;
    logic [4:0]  req_rd;
    logic        stall;
    logic        resp_valid;
    logic [63:0] resp_data;
    logic [4:0]  resp_rd;
    logic        xcpt_valid;
    logic [3:0]  xcpt_cause;
    logic        dmem_req_valid;
    logic        dmem_req_ready;
    logic [4:0]  dmem_req_cmd;
    logic [2:0]  dmem_op_type;
    logic [39:0] dmem_req_bits_addr;
    logic [63:0] dmem_req_bits_data;
    logic [7:0]  dmem_req_bits_tag;
    logic        dmem_req_bits_kill;
    logic        dmem_resp_valid;
    logic [7:0]  dmem_resp_bits_tag;
    logic [63:0] dmem_resp_bits_data_subw;
    logic        dmem_resp_bits_has_data;
    logic        dmem_resp_bits_nack;
    logic        dmem_xcpt_ma_ld;
    logic        dmem_xcpt_ma_st;
    logic        dmem_xcpt_pf_ld;
    logic        dmem_xcpt_pf_st;

    dmem_interface dut (
        .clk(clk), .rst(rst), .kill(kill),
        .req_valid(req_valid), .req_cmd(req_cmd), .req_type(req_type),
        .req_addr(req_addr), .req_data(req_data), .req_rd(req_rd),
        .stall(stall), .resp_valid(resp_valid), .resp_data(resp_data), .resp_rd(resp_rd),
        .xcpt_valid(xcpt_valid), .xcpt_cause(xcpt_cause),
        .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
        .dmem_req_cmd(dmem_req_cmd), .dmem_op_type(dmem_op_type),
        .dmem_req_bits_addr(dmem_req_bits_addr), .dmem_req_bits_data(dmem_req_bits_data),
        .dmem_req_bits_tag(dmem_req_bits_tag), .dmem_req_bits_kill(dmem_req_bits_kill),
        .dmem_resp_valid(dmem_resp_valid), .dmem_resp_bits_tag(dmem_resp_bits_tag),
        .dmem_resp_bits_data_subw(dmem_resp_bits_data_subw),
        .dmem_resp_bits_has_data(dmem_resp_bits_has_data),
        .dmem_resp_bits_nack(dmem_resp_bits_nack),
        .dmem_xcpt_ma_ld(dmem_xcpt_ma_ld), .dmem_xcpt_ma_st(dmem_xcpt_ma_st),
        .dmem_xcpt_pf_ld(dmem_xcpt_pf_ld), .dmem_xcpt_pf_st(dmem_xcpt_pf_st)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  tag;
        logic [4:0]  cmd;
        logic [2:0]  typ;
        logic [39:0] addr;
        logic [63:0] data;
    } iss_t;

    typedef struct {
        logic [63:0] data;
        logic [4:0]  rd;
    } rsp_t;

    iss_t       iq[$];
    rsp_t       rq[$];
    logic [3:0] xq[$];

    int total = 0;
    int bad   = 0;

    // scoreboard monitor: every DMEM acceptance, completion and exception pops an expectation
    always @(negedge clk) begin
        if (!rst) begin
            if (dmem_req_valid && dmem_req_ready) begin
                total++;
                if (iq.size() == 0) begin
                    bad++;
                    $display("FAIL issue: unexpected acceptance tag=%h addr=%h", dmem_req_bits_tag, dmem_req_bits_addr);
                end else begin
                    iss_t e;
                    e = iq.pop_front();
                    if (dmem_req_bits_tag !== e.tag || dmem_req_cmd !== e.cmd || dmem_op_type !== e.typ ||
                        dmem_req_bits_addr !== e.addr || dmem_req_bits_data !== e.data) begin
                        bad++;
                        $display("FAIL issue: got tag=%h cmd=%h typ=%h addr=%h data=%h want tag=%h cmd=%h typ=%h addr=%h data=%h",
                                 dmem_req_bits_tag, dmem_req_cmd, dmem_op_type, dmem_req_bits_addr, dmem_req_bits_data,
                                 e.tag, e.cmd, e.typ, e.addr, e.data);
                    end
                end
            end
            if (resp_valid) begin
                total++;
                if (rq.size() == 0) begin
                    bad++;
                    $display("FAIL resp: unexpected resp data=%h rd=%0d", resp_data, resp_rd);
                end else begin
                    rsp_t r;
                    r = rq.pop_front();
                    if (resp_data !== r.data || resp_rd !== r.rd) begin
                        bad++;
                        $display("FAIL resp: got data=%h rd=%0d want data=%h rd=%0d", resp_data, resp_rd, r.data, r.rd);
                    end
                end
            end
            if (xcpt_valid) begin
                total++;
                if (xq.size() == 0) begin
                    bad++;
                    $display("FAIL xcpt: unexpected xcpt cause=%0d", xcpt_cause);
                end else begin
                    logic [3:0] c;
                    c = xq.pop_front();
                    if (xcpt_cause !== c) begin
                        bad++;
                        $display("FAIL xcpt: got cause=%0d want %0d", xcpt_cause, c);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic idle_in();
        kill                     = 1'b0;
        dmem_resp_valid          = 1'b0;
        dmem_resp_bits_tag       = 8'h00;
        dmem_resp_bits_data_subw = 64'd0;
        dmem_resp_bits_has_data  = 1'b0;
        dmem_resp_bits_nack      = 1'b0;
        dmem_xcpt_ma_ld          = 1'b0;
        dmem_xcpt_ma_st          = 1'b0;
        dmem_xcpt_pf_ld          = 1'b0;
        dmem_xcpt_pf_st          = 1'b0;
    endtask

    task automatic set_req(input logic [4:0] cmd, input logic [2:0] typ, input logic [39:0] addr,
                           input logic [63:0] data, input logic [4:0] rd);
        req_cmd  = cmd;
        req_type = typ;
        req_addr = addr;
        req_data = data;
        req_rd   = rd;
    endtask

    task automatic push_iss(input logic [7:0] tag);
        iss_t e;
        e.tag  = tag;
        e.cmd  = req_cmd;
        e.typ  = req_type;
        e.addr = req_addr;
        e.data = req_data;
        iq.push_back(e);
    endtask

    task automatic push_rsp(input logic [63:0] data, input logic [4:0] rd);
        rsp_t r;
        r.data = data;
        r.rd   = rd;
        rq.push_back(r);
    endtask

    task automatic respond(input logic [7:0] tag, input logic [63:0] data, input logic has);
        dmem_resp_valid          = 1'b1;
        dmem_resp_bits_tag       = tag;
        dmem_resp_bits_data_subw = data;
        dmem_resp_bits_has_data  = has;
    endtask

    // minimum-latency load starting in IDLE: response arrives in CHECK
    task automatic load_op(input string name, input logic [39:0] addr, input logic [4:0] rd,
                           input logic [63:0] data, input logic [7:0] tag);
        set_req(5'd0, 3'd3, addr, 64'd0, rd);
        push_iss(tag);
        push_rsp(data, rd);
        req_valid = 1'b1;
        at_neg(); chk({name, "_stall_c0"}, stall, 1);
        step(); req_valid = 1'b0;
        at_neg(); chk({name, "_stall_c1"}, stall, 1);
        step(); respond(tag, data, 1'b1);
        at_neg(); chk({name, "_stall_c2"}, stall, 1);
        step(); idle_in();
        at_neg(); chk({name, "_resp_c3"}, resp_valid, 1); chk({name, "_stall_c3"}, stall, 0);
        step();
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0;
        dmem_req_ready = 1'b1;
        set_req(5'd0, 3'd0, 40'd0, 64'd0, 5'd0);
        idle_in();
        step(); step();
        at_neg();
        chk("rst_stall", stall, 0);
        chk("rst_req_valid", dmem_req_valid, 0);
        chk("rst_req_kill", dmem_req_bits_kill, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_xcpt_valid", xcpt_valid, 0);
        chk("rst_tag", dmem_req_bits_tag, 0);
        chk("rst_addr", dmem_req_bits_addr, 0);
        step(); rst = 1'b0;
        step();

        // 1: minimum-latency load, tag 0x00
        load_op("load", 40'h80001000, 5'd5, 64'hFFFFFFFFFFFFFF80, 8'h00);

        // 2: store with three cycles of ready low, tag 0x01
        set_req(5'd1, 3'd3, 40'h00002040, 64'hDEADBEEFCAFEF00D, 5'd7);
        push_iss(8'h01);
        push_rsp(64'd0, 5'd7);
        req_valid = 1'b1;
        dmem_req_ready = 1'b0;
        step(); req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) dmem_req_ready = 1'b1;
            at_neg();
            chk("bp_valid", dmem_req_valid, 1);
            chk("bp_addr", dmem_req_bits_addr, 64'h00002040);
            chk("bp_data", dmem_req_bits_data, 64'hDEADBEEFCAFEF00D);
            chk("bp_tag", dmem_req_bits_tag, 8'h01);
            step();
        end
        // CHECK: nothing, go to WAIT
        at_neg(); chk("st_check_stall", stall, 1);
        step(); respond(8'h01, 64'h1234, 1'b0);
        step(); idle_in();
        at_neg(); chk("st_resp", resp_valid, 1);
        step();

        // 3: exception priority MA_LD over PF_LD, same-cycle response ignored, tag 0x02
        set_req(5'd0, 3'd2, 40'h00003001, 64'd0, 5'd9);
        push_iss(8'h02);
        xq.push_back(4'd4);
        req_valid = 1'b1;
        step(); req_valid = 1'b0;
        step(); respond(8'h02, 64'h55, 1'b1); dmem_xcpt_ma_ld = 1'b1; dmem_xcpt_pf_ld = 1'b1;
        step(); idle_in();
        at_neg(); chk("xc_valid", xcpt_valid, 1); chk("xc_no_resp", resp_valid, 0);
        step();

        // 4: NACK retry from fresh reset: tags 0,1,2; stale tag 1 ignored
        rst = 1'b1; step(); rst = 1'b0; step();
        set_req(5'd0, 3'd3, 40'h00004000, 64'd0, 5'd3);
        push_iss(8'h00); push_iss(8'h01); push_iss(8'h02);
        push_rsp(64'h0000000011112222, 5'd3);
        req_valid = 1'b1;
        step(); req_valid = 1'b0;               // ISSUE tag0
        step(); dmem_resp_bits_nack = 1'b1;     // CHECK
        step(); idle_in();                      // ISSUE tag1
        step();                                 // CHECK -> WAIT
        step(); dmem_resp_bits_nack = 1'b1;     // WAIT
        step(); idle_in();                      // ISSUE tag2
        step(); respond(8'h01, 64'hBAD, 1'b1);  // CHECK, stale
        at_neg(); chk("nk_stale_stall", stall, 1);
        step(); respond(8'h02, 64'h0000000011112222, 1'b1);
        at_neg(); chk("nk_no_early_resp", resp_valid, 0);
        step(); idle_in();
        at_neg(); chk("nk_resp", resp_valid, 1);
        step();

        // 5a: kill in CHECK, tag 0x03
        set_req(5'd0, 3'd3, 40'h00005000, 64'd0, 5'd4);
        push_iss(8'h03);
        req_valid = 1'b1;
        step(); req_valid = 1'b0;
        step(); kill = 1'b1;
        at_neg(); chk("kl_req_kill", dmem_req_bits_kill, 1);
        step(); kill = 1'b0;
        at_neg(); chk("kl_stall_drain", stall, 0); chk("kl_req_kill_off", dmem_req_bits_kill, 0);
        step(); respond(8'h03, 64'h77, 1'b1);
        step(); idle_in();
        at_neg(); chk("kl_no_resp", resp_valid, 0);
        step();

        // 5b: NACK storm walks the tag up to 0xFF, then wrap to 0x00
        set_req(5'd0, 3'd3, 40'h00006000, 64'd0, 5'd6);
        for (int t = 4; t < 256; t++) push_iss(8'(t));
        push_rsp(64'h00000000000000AB, 5'd6);
        req_valid = 1'b1;
        step(); req_valid = 1'b0;
        for (int t = 4; t < 255; t++) begin
            step(); dmem_resp_bits_nack = 1'b1;
            step(); dmem_resp_bits_nack = 1'b0;
        end
        at_neg(); chk("wr_tag_ff", dmem_req_bits_tag, 8'hFF);
        step(); respond(8'hFF, 64'h00000000000000AB, 1'b1);
        step(); idle_in();
        at_neg(); chk("wr_resp_ff", resp_valid, 1);
        step();
        load_op("wrap", 40'h00006008, 5'd8, 64'h0000000000000C0D, 8'h00);

        // 6: reset in WAIT, old tag 0x01 ignored, new load uses tag 0x00
        set_req(5'd0, 3'd3, 40'h00007000, 64'd0, 5'd10);
        push_iss(8'h01);
        req_valid = 1'b1;
        step(); req_valid = 1'b0;   // ISSUE tag1
        step();                     // CHECK -> WAIT
        step(); rst = 1'b1;         // WAIT
        step(); rst = 1'b0;
        at_neg();
        chk("rm_stall", stall, 0);
        chk("rm_req_valid", dmem_req_valid, 0);
        chk("rm_resp_valid", resp_valid, 0);
        chk("rm_xcpt_valid", xcpt_valid, 0);
        chk("rm_tag", dmem_req_bits_tag, 0);
        chk("rm_addr", dmem_req_bits_addr, 0);
        step(); respond(8'h01, 64'h99, 1'b1);
        step(); idle_in();
        at_neg(); chk("rm_old_ignored", resp_valid, 0); chk("rm_idle_stall", stall, 0);
        step();
        load_op("post_rst", 40'h00008000, 5'd11, 64'h0123456789ABCDEF, 8'h00);

        step(); step();
        chk("iss_q_empty", 64'(iq.size()), 0);
        chk("rsp_q_empty", 64'(rq.size()), 0);
        chk("xcpt_q_empty", 64'(xq.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_interface.md
# dmem_interface

Load/store unit between the execution stage and the D-cache port of the core. It captures one memory operation from execution and issues it on the DMEM request channel with a rolling tag. It tracks the outstanding request through exception check, NACK-driven reissue, kill and response, then returns load data, or a memory exception, to write-back. The pipeline is stalled for the whole transaction.

## Interface
- No parameters; tag width fixed at 8, address at 40, data at 64.
- CLK  in  1  core clock
- RST  in  1  synchronous, active-high reset
- KILL  in  1  flush from control; aborts the in-flight operation
- REQ_VALID / REQ_CMD / REQ_TYPE  in  1/5/3  operation from execution; held stable while STALL=1
- REQ_ADDR / REQ_DATA / REQ_RD  in  40/64/5  address, store data, destination register
- STALL  out  1  freezes IF..EXE
- RESP_VALID / RESP_DATA / RESP_RD  out  1/64/5  one-cycle completion to write-back; RESP_DATA is 0 for stores
- XCPT_VALID / XCPT_CAUSE  out  1/4  one-cycle memory exception to control
- DMEM_REQ_VALID / DMEM_REQ_READY  out/in  1/1  request handshake
- DMEM_REQ_CMD / DMEM_OP_TYPE  out  5/3  registered copies of REQ_CMD and REQ_TYPE
- DMEM_REQ_BITS_ADDR / DMEM_REQ_BITS_DATA / DMEM_REQ_BITS_TAG  out  40/64/8  request payload
- DMEM_REQ_BITS_KILL  out  1  aborts the request accepted in the previous cycle
- DMEM_RESP_VALID / DMEM_RESP_BITS_TAG / DMEM_RESP_BITS_DATA_SUBW / DMEM_RESP_BITS_HAS_DATA  in  1/8/64/1  response channel
- DMEM_RESP_BITS_NACK  in  1  standalone pulse; the outstanding request was rejected
- DMEM_XCPT_MA_LD / MA_ST / PF_LD / PF_ST  in  1 each  valid only in the cycle after acceptance

## Operation
- **Payload register.** Holds cmd, type, addr, data, rd. Loaded in IDLE when REQ_VALID=1 and KILL=0.
- **Tag counter.** 8-bit, increments on every accepted request (DMEM_REQ_VALID & DMEM_REQ_READY). Wraps 255 -> 0. Reset value 0.
- **IDLE**
  - REQ_VALID & !KILL -> ISSUE.
  - STALL = REQ_VALID & !KILL (combinational).
- **ISSUE**
  - DMEM_REQ_VALID=1; DMEM_REQ_BITS_TAG = current tag.
  - Accepted -> CHECK.
  - KILL -> IDLE without issuing.
- **CHECK** (exactly one cycle after acceptance)
  - Any DMEM_XCPT_* -> DONE with XCPT_VALID. Cause priority: MA_LD=4 > MA_ST=6 > PF_LD=13 > PF_ST=15. Any response or NACK in the same cycle is ignored.
  - Else KILL -> DMEM_REQ_BITS_KILL=1 this cycle -> DRAIN.
  - Else NACK -> ISSUE, reissuing the same payload with the next tag.
  - Else a matching response -> DONE.
  - Else -> WAIT.
- **WAIT**
  - NACK -> ISSUE.
  - DMEM_RESP_VALID with tag == issued tag -> DONE.
  - KILL -> DRAIN.
  - Responses with a mismatched tag are discarded.
- **DRAIN** (killed)
  - Matching response or NACK -> IDLE; nothing is reported.
  - STALL=0.
- **DONE**
  - Registered one-cycle pulse of RESP_VALID or XCPT_VALID. RESP_DATA = DATA_SUBW if HAS_DATA, else 0.
  - STALL=0; REQ_VALID is ignored this cycle (it is the retiring op).
  - -> IDLE.
- **STALL.** 1 in ISSUE, CHECK, WAIT; 0 in DRAIN and DONE.
- **Simultaneous events.** NACK and a matching response in the same cycle: NACK wins, and the operation reissues.

## Timing
- **Reset values.** All outputs 0 (DMEM_REQ_VALID, DMEM_REQ_BITS_KILL, RESP_VALID, XCPT_VALID, STALL and all payload outputs); state IDLE; tag 0.
- **Reset mid-operation.** Any state -> IDLE next cycle; the outstanding request is abandoned and its late responses are ignored by tag mismatch.
- **Minimum load latency.** REQ_VALID at cycle 0, ISSUE accepted at cycle 1, response in CHECK at cycle 2, RESP_VALID at cycle 3. STALL is high in cycles 0-2.
- **Ready low.** Each cycle of DMEM_REQ_READY=0 in ISSUE adds one cycle.
- **Stable payload.** DMEM payload holds stable while in ISSUE.
- **Retries.** There is no retry limit; each NACK costs at least 2 cycles.

## Test plan
1. **Load.** Load of addr 0x80001000, rd=5, ready=1; response tag 0x00, DATA_SUBW=0xFFFFFFFFFFFFFF80 in the cycle after acceptance -> RESP_VALID at cycle 3, RESP_DATA=0xFFFFFFFFFFFFFF80, RESP_RD=5, STALL high cycles 0-2.
2. **Store with back-pressure.** DMEM_REQ_READY low for 3 cycles -> DMEM_REQ_VALID held for 4 cycles with stable payload; response with HAS_DATA=0 -> RESP_VALID with RESP_DATA=0.
3. **Exception priority.** Load with MA_LD=1 and PF_LD=1 in CHECK, plus a same-cycle response -> XCPT_VALID with XCPT_CAUSE=4, no RESP_VALID.
4. **NACK retry.** Two NACKs, then a response -> three acceptances carrying tags 0x00, 0x01, 0x02; a stale response with tag 0x01 arriving after the third issue is ignored; RESP_VALID follows only the tag-0x02 response.
5. **Kill.** KILL in CHECK -> DMEM_REQ_BITS_KILL=1 for exactly that cycle, STALL=0 next cycle, later matching response produces no RESP_VALID. Separately, preload tag=0xFF and issue -> next request uses tag 0x00.
6. **Reset mid-operation.** RST asserted in WAIT -> all outputs 0 next cycle; a later response with the old tag produces nothing; a new load then issues with tag 0x00.
